// File: rtl/simplez_io_responder.sv
// Simplez memory-port responder: RAM pass-through plus LED, 8N1 TX, STATUS and TIMER registers.
// Optional one-entry TX holding buffer when SIMPLEZ_IO_TXBUF_EN is defined.
module simplez_io_responder #(
  parameter int unsigned    AW       = 9,
  parameter int unsigned    DW       = 12,
  parameter logic [AW-1:0]  IO_BASE  = 'h1FC,
  parameter int unsigned    BAUD_DIV = 104,
  parameter int unsigned    TICK_DIV = 2400000
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [AW-1:0] addr,
  input  logic          rw,
  input  logic [DW-1:0] data_in,
  input  logic [DW-1:0] ram_dout,
  output logic          ram_rw,
  output logic [DW-1:0] data_out,
  output logic [3:0]    leds,
  output logic          tx
);

  localparam int unsigned BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [AW:0] IO_LAST = {1'b0, IO_BASE} + (AW+1)'(3);

  typedef enum logic [1:0] {
    OFF_LEDS   = 2'd0,
    OFF_TXDATA = 2'd1,
    OFF_STATUS = 2'd2,
    OFF_TIMER  = 2'd3
  } io_off_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  // Address decode
  logic    io_hit;
  io_off_t offset;
  logic    io_wr;
  logic    tx_wr;
  logic    tx_wr_q;
  logic    tx_take;
  logic    status_rd;

  assign io_hit    = (addr >= IO_BASE) && ({1'b0, addr} <= IO_LAST);
  // Only the low two bits of the difference matter, and they depend only on the low address bits.
  assign offset    = io_off_t'(addr[1:0] - IO_BASE[1:0]);
  assign io_wr     = io_hit && !rw;
  assign tx_wr     = io_wr && (offset == OFF_TXDATA);
  assign tx_take   = tx_wr && !tx_wr_q;
  assign status_rd = io_hit && rw && (offset == OFF_STATUS);

  // I/O writes must never reach RAM, so the RAM sees a read instead.
  assign ram_rw = io_hit ? 1'b1 : rw;

  logic unused_data_bits;
  assign unused_data_bits = ^data_in[DW-1:8];

  // Transmitter state
  tx_state_t       state;
  logic [BW-1:0]   baud_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            baud_done;
  logic            stop_end;
  logic            tx_busy;
  logic            txbuf_full;

  assign baud_done = (baud_cnt == BW'(BAUD_DIV - 1));
  assign stop_end  = (state == TX_STOP) && baud_done;
  assign tx_busy   = (state != TX_IDLE);

`ifdef SIMPLEZ_IO_TXBUF_EN
  logic [7:0] buf_data;
  logic       buf_full;

  assign txbuf_full = buf_full;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      buf_data <= '0;
      buf_full <= 1'b0;
    end else if (stop_end && buf_full) begin
      buf_full <= 1'b0;
    end else if (tx_take && tx_busy && !buf_full && !stop_end) begin
      buf_data <= data_in[7:0];
      buf_full <= 1'b1;
    end
  end
`else
  assign txbuf_full = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= TX_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
      tx_wr_q  <= 1'b0;
    end else begin
      tx_wr_q <= tx_wr;
      if (state != TX_IDLE) begin
        baud_cnt <= baud_done ? '0 : baud_cnt + BW'(1);
      end
      unique case (state)
        TX_IDLE: begin
          if (tx_take) begin
            state    <= TX_START;
            tx       <= 1'b0;
            baud_cnt <= '0;
            shreg    <= data_in[7:0];
          end
        end
        TX_START: begin
          if (baud_done) begin
            state   <= TX_DATA;
            tx      <= shreg[0];
            bit_idx <= '0;
          end
        end
        TX_DATA: begin
          if (baud_done) begin
            if (bit_idx == 3'd7) begin
              state <= TX_STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shreg   <= shreg >> 1;
              tx      <= shreg[1];
            end
          end
        end
        TX_STOP: begin
          if (baud_done) begin
`ifdef SIMPLEZ_IO_TXBUF_EN
            // A queued byte, or one arriving on this very edge, chains straight into START.
            if (buf_full || tx_take) begin
              state <= TX_START;
              tx    <= 1'b0;
              shreg <= buf_full ? buf_data : data_in[7:0];
            end else begin
              state <= TX_IDLE;
            end
`else
            state <= TX_IDLE;
`endif
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

  // Tick timer; a tick on the same edge as a STATUS read keeps the flag set.
  logic [TW-1:0] presc;
  logic [DW-1:0] timer;
  logic          tick_flag;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      presc     <= '0;
      timer     <= '0;
      tick_flag <= 1'b0;
    end else if (presc == TW'(TICK_DIV - 1)) begin
      presc     <= '0;
      timer     <= timer + DW'(1);
      tick_flag <= 1'b1;
    end else begin
      presc <= presc + TW'(1);
      if (status_rd) begin
        tick_flag <= 1'b0;
      end
    end
  end

  // LED register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      leds <= '0;
    end else if (io_wr && (offset == OFF_LEDS)) begin
      leds <= data_in[3:0];
    end
  end

  // Read path: I/O data captured on the same edge genram registers its read.
  logic [DW-1:0] status;
  logic [DW-1:0] io_rdata_q;
  logic          io_hit_q;

  assign status = {{(DW-3){1'b0}}, txbuf_full, tick_flag, tx_busy};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      io_hit_q   <= 1'b0;
      io_rdata_q <= '0;
    end else begin
      io_hit_q <= io_hit;
      unique case (offset)
        OFF_LEDS:   io_rdata_q <= {{(DW-4){1'b0}}, leds};
        OFF_TXDATA: io_rdata_q <= '0;
        OFF_STATUS: io_rdata_q <= status;
        OFF_TIMER:  io_rdata_q <= timer;
        default:    io_rdata_q <= '0;
      endcase
    end
  end

  assign data_out = io_hit_q ? io_rdata_q : ram_dout;

endmodule

// File: tb/tb_simplez_io_responder.sv
// Directed bench for simplez_io_responder with BAUD_DIV=4 and TICK_DIV=8.
// Works with or without SIMPLEZ_IO_TXBUF_EN defined.
module tb_simplez_io_responder;

  localparam int BAUD = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [8:0]  addr = '0;
  logic        rw = 1'b1;
  logic [11:0] data_in = '0;
  logic [11:0] ram_dout = '0;
  logic        ram_rw;
  logic [11:0] data_out;
  logic [3:0]  leds;
  logic        tx;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  simplez_io_responder #(
    .AW(9), .DW(12), .IO_BASE(9'h1FC), .BAUD_DIV(BAUD), .TICK_DIV(8)
  ) dut (
    .clk(clk), .rstn(rstn), .addr(addr), .rw(rw), .data_in(data_in),
    .ram_dout(ram_dout), .ram_rw(ram_rw), .data_out(data_out), .leds(leds), .tx(tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Serial line monitor: decodes 8N1 frames, stores {stop, byte} and start cycle.
  logic [8:0] rx_q[$];
  int         rx_t[$];
  bit         mon_active = 0;
  int         mon_cnt = 0;
  int         mon_t = 0;
  logic [7:0] mon_byte = '0;

  always @(negedge clk) begin
    if (!rstn) begin
      mon_active = 0;
    end else if (!mon_active) begin
      if (tx === 1'b0) begin
        mon_active = 1;
        mon_cnt = 0;
        mon_byte = '0;
        mon_t = cyc;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt >= BAUD && mon_cnt < 9*BAUD && (mon_cnt % BAUD) == BAUD/2)
        mon_byte[mon_cnt/BAUD - 1] = tx;
      if (mon_cnt == 9*BAUD + BAUD/2) begin
        rx_q.push_back({tx, mon_byte});
        rx_t.push_back(mon_t);
        mon_active = 0;
      end
    end
  end

  task automatic bus_idle();
    addr = 9'h000;
    rw = 1'b1;
    data_in = '0;
  endtask

  task automatic bus_write(input logic [8:0] a, input logic [11:0] d);
    addr = a;
    rw = 1'b0;
    data_in = d;
    @(posedge clk);
    @(negedge clk);
    bus_idle();
  endtask

  task automatic bus_read(input logic [8:0] a, output logic [11:0] d);
    addr = a;
    rw = 1'b1;
    @(posedge clk);
    @(negedge clk);
    d = data_out;
    bus_idle();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    bus_idle();
    ram_dout = '0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    logic [11:0] d;
    do_reset();
    bus_write(9'h1FC, 12'h00F);
    bus_write(9'h1FD, 12'h000);
    repeat (6) @(negedge clk);
    checks++;
    if (tx !== 1'b0) begin
      errors++;
      $display("FAIL reset_pre_tx got %b want 0", tx);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1) begin
      errors++;
      $display("FAIL reset_tx got %b want 1", tx);
    end
    checks++;
    if (leds !== 4'h0) begin
      errors++;
      $display("FAIL reset_leds got %h want 0", leds);
    end
    checks++;
    if (data_out !== 12'h000) begin
      errors++;
      $display("FAIL reset_data_out got %h want 000", data_out);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    bus_read(9'h1FE, d);
    checks++;
    if (d !== 12'h000) begin
      errors++;
      $display("FAIL reset_status got %h want 000", d);
    end
    repeat (60) @(negedge clk);
    checks++;
    if (tx !== 1'b1) begin
      errors++;
      $display("FAIL reset_no_resume got %b want 1", tx);
    end
  endtask

  task automatic test_leds();
    logic [11:0] d;
    bus_write(9'h1FC, 12'hFF5);
    checks++;
    if (leds !== 4'h5) begin
      errors++;
      $display("FAIL leds_upper got %h want 5", leds);
    end
    bus_read(9'h1FC, d);
    checks++;
    if (d !== 12'h005) begin
      errors++;
      $display("FAIL leds_read_upper got %h want 005", d);
    end
    bus_write(9'h1FC, 12'h00A);
    checks++;
    if (leds !== 4'hA) begin
      errors++;
      $display("FAIL leds_write got %h want A", leds);
    end
    bus_read(9'h1FC, d);
    checks++;
    if (d !== 12'h00A) begin
      errors++;
      $display("FAIL leds_read got %h want 00A", d);
    end
    bus_read(9'h1FD, d);
    checks++;
    if (d !== 12'h000) begin
      errors++;
      $display("FAIL txdata_read got %h want 000", d);
    end
  endtask

  task automatic test_tx_frame();
    logic [11:0] d;
    logic [7:0]  byte_v;
    logic        exp;
    byte_v = 8'h55;
    rx_q.delete();
    rx_t.delete();
    bus_write(9'h1FD, 12'h055);
    for (int i = 0; i < 40; i++) begin
      if (i < BAUD) exp = 1'b0;
      else if (i < 9*BAUD) exp = byte_v[(i - BAUD) / BAUD];
      else exp = 1'b1;
      checks++;
      if (tx !== exp) begin
        errors++;
        $display("FAIL tx_wave[%0d] got %b want %b", i, tx, exp);
      end
      @(negedge clk);
    end
    bus_read(9'h1FE, d);
    checks++;
    if ((d & 12'hFFD) !== 12'h000) begin
      errors++;
      $display("FAIL tx_status_after got %h want busy=0", d);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 9'h155) begin
      errors++;
      $display("FAIL tx_frame got %0d frames first %h want 1 frame 155", rx_q.size(),
               (rx_q.size() > 0) ? rx_q[0] : 9'h000);
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] d;
    rx_q.delete();
    rx_t.delete();
    bus_write(9'h1FD, 12'h041);
    bus_read(9'h1FE, d);
    checks++;
    if ((d & 12'hFFD) !== 12'h001) begin
      errors++;
      $display("FAIL b2b_status1 got %h want 001", d);
    end
    bus_write(9'h1FD, 12'h042);
    bus_read(9'h1FE, d);
`ifdef SIMPLEZ_IO_TXBUF_EN
    checks++;
    if ((d & 12'hFFD) !== 12'h005) begin
      errors++;
      $display("FAIL b2b_status2 got %h want 005", d);
    end
`else
    checks++;
    if ((d & 12'hFFD) !== 12'h001) begin
      errors++;
      $display("FAIL b2b_status2 got %h want 001", d);
    end
`endif
    repeat (120) @(negedge clk);
`ifdef SIMPLEZ_IO_TXBUF_EN
    checks++;
    if (rx_q.size() != 2 || rx_q[0] !== 9'h141 || rx_q[1] !== 9'h142) begin
      errors++;
      $display("FAIL b2b_frames got %0d frames want 141,142", rx_q.size());
    end else begin
      checks++;
      if (rx_t[1] - rx_t[0] != 10*BAUD) begin
        errors++;
        $display("FAIL b2b_gap got %0d want %0d", rx_t[1] - rx_t[0], 10*BAUD);
      end
    end
`else
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 9'h141) begin
      errors++;
      $display("FAIL b2b_frames got %0d frames want one 141", rx_q.size());
    end
`endif
  endtask

  task automatic test_held_write();
    rx_q.delete();
    rx_t.delete();
    addr = 9'h1FD;
    rw = 1'b0;
    data_in = 12'h033;
    repeat (3) @(negedge clk);
    bus_idle();
    repeat (100) @(negedge clk);
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 9'h133) begin
      errors++;
      $display("FAIL held_write got %0d frames want one 133", rx_q.size());
    end
  endtask

  task automatic test_ram_passthrough();
    logic [11:0] d;
    addr = 9'h010; rw = 1'b0; data_in = 12'h123;
    #1;
    checks++;
    if (ram_rw !== 1'b0) begin
      errors++;
      $display("FAIL ram_write_rw got %b want 0", ram_rw);
    end
    @(negedge clk);
    addr = 9'h1FB;
    #1;
    checks++;
    if (ram_rw !== 1'b0) begin
      errors++;
      $display("FAIL ram_edge_rw got %b want 0", ram_rw);
    end
    @(negedge clk);
    addr = 9'h1FE; data_in = 12'hFFF;
    #1;
    checks++;
    if (ram_rw !== 1'b1) begin
      errors++;
      $display("FAIL io_write_rw got %b want 1", ram_rw);
    end
    @(negedge clk);
    bus_idle();
    ram_dout = 12'h5A5;
    bus_read(9'h010, d);
    checks++;
    if (d !== 12'h5A5) begin
      errors++;
      $display("FAIL ram_read got %h want 5A5", d);
    end
    bus_read(9'h1FC, d);
    checks++;
    if (d !== 12'h00A) begin
      errors++;
      $display("FAIL io_over_ram got %h want 00A", d);
    end
    bus_read(9'h1FE, d);
    checks++;
    if ((d & 12'hFFD) !== 12'h000) begin
      errors++;
      $display("FAIL status_write_ignored got %h want 000", d);
    end
    checks++;
    if (leds !== 4'hA) begin
      errors++;
      $display("FAIL leds_kept got %h want A", leds);
    end
    ram_dout = '0;
  endtask

  task automatic test_tick();
    logic [11:0] d;
    do_reset();
    repeat (24) @(posedge clk);
    @(negedge clk);
    bus_read(9'h1FF, d);
    checks++;
    if (d !== 12'h003) begin
      errors++;
      $display("FAIL timer got %h want 003", d);
    end
    bus_read(9'h1FE, d);
    checks++;
    if (d[1] !== 1'b1) begin
      errors++;
      $display("FAIL tick_flag_set got %b want 1", d[1]);
    end
    bus_read(9'h1FE, d);
    checks++;
    if (d[1] !== 1'b0) begin
      errors++;
      $display("FAIL tick_flag_clear got %b want 0", d[1]);
    end
  endtask

  initial begin
    test_reset();
    test_leds();
    test_tx_frame();
    test_back_to_back();
    test_held_write();
    test_ram_passthrough();
    test_tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
